// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - instruction-memory bus between the fetch stage and imem
interface if_id_stage_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;

   // fetch stage drives the address, memory returns the word in the same cycle
   modport master (output imem_addr, input imem_rdata);
   modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - fetch stage + IF/ID register with pre-decode (optional macro IF_PERF_COUNTER_EN)
module if_id_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   if_id_stage_if.master imem,
   output logic [31:0] IF_ID_pc,
   output logic [31:0] IF_ID_pc_plus4,
   output logic [31:0] IF_ID_instr,
   output logic        IF_ID_valid,
   output logic [4:0]  IF_ID_rs1,
   output logic [4:0]  IF_ID_rs2,
   output logic        IF_ID_is_Branch
`ifdef IF_PERF_COUNTER_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   logic [31:0] pc;
   logic [6:0]  opcode;

   // a redirect only takes effect when the pipeline is not frozen
   logic        do_redirect;
   assign do_redirect = !stall && branch_taken;

   // PC register: stall holds, redirect loads word-aligned target, otherwise sequential
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (!stall) begin
         if (branch_taken) begin
            pc <= {branch_target[31:2], 2'b00};
         end else begin
            pc <= pc + 32'd4;
         end
      end
   end

   // IF/ID register: redirect squashes the wrong-path fetch into a bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         IF_ID_pc    <= RESET_PC;
         IF_ID_instr <= NOP_INSTR;
         IF_ID_valid <= 1'b0;
      end else if (!stall) begin
         IF_ID_pc <= pc;
         if (branch_taken) begin
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
         end else begin
            IF_ID_instr <= imem.imem_rdata;
            IF_ID_valid <= 1'b1;
         end
      end
   end

   assign imem.imem_addr = pc;

   // pre-decode looks only at registered state, so it is stable all cycle
   assign opcode          = IF_ID_instr[6:0];
   assign IF_ID_pc_plus4  = IF_ID_pc + 32'd4;
   assign IF_ID_rs1       = IF_ID_instr[19:15];
   assign IF_ID_rs2       = IF_ID_instr[24:20];
   assign IF_ID_is_Branch = IF_ID_valid && ((opcode == OPC_BRANCH) || (opcode == OPC_JALR));

`ifdef IF_PERF_COUNTER_EN
   // saturating event counters for stall cycles and taken redirects
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt <= 32'd0;
         perf_flush_cnt <= 32'd0;
      end else begin
         if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (do_redirect && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
      end
   end
`else
   logic unused_redirect;
   assign unused_redirect = do_redirect;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed self-checking bench for if_id_stage
module tb_if_id_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] IF_ID_pc;
   logic [31:0] IF_ID_pc_plus4;
   logic [31:0] IF_ID_instr;
   logic        IF_ID_valid;
   logic [4:0]  IF_ID_rs1;
   logic [4:0]  IF_ID_rs2;
   logic        IF_ID_is_Branch;
`ifdef IF_PERF_COUNTER_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;
   logic [31:0] stall_base;
   logic [31:0] flush_base;
`endif

   int checks   = 0;
   int failures = 0;

   if_id_stage_if imem_bus ();

   if_id_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .branch_taken    (branch_taken),
      .branch_target   (branch_target),
      .imem            (imem_bus),
      .IF_ID_pc        (IF_ID_pc),
      .IF_ID_pc_plus4  (IF_ID_pc_plus4),
      .IF_ID_instr     (IF_ID_instr),
      .IF_ID_valid     (IF_ID_valid),
      .IF_ID_rs1       (IF_ID_rs1),
      .IF_ID_rs2       (IF_ID_rs2),
      .IF_ID_is_Branch (IF_ID_is_Branch)
`ifdef IF_PERF_COUNTER_EN
      ,
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_flush_cnt  (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // instruction memory: beq at 0x4, add at 0x8, otherwise an R-type add with rd tagged by address
   function automatic logic [31:0] instr_at(input logic [31:0] a);
      if (a == 32'h4) return 32'h0020_8463;
      if (a == 32'h8) return 32'h00C5_8533;
      return 32'h0000_0033 | {20'd0, a[6:2], 7'd0};
   endfunction

   always_comb imem_bus.imem_rdata = instr_at(imem_bus.imem_addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      step(); step();
      checks++; if (imem_bus.imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=%h", imem_bus.imem_addr, 32'h0); end
      checks++; if (IF_ID_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", IF_ID_valid); end
      checks++; if (IF_ID_instr !== 32'h13) begin failures++; $display("FAIL rst_instr got=%h exp=%h", IF_ID_instr, 32'h13); end
      checks++; if (IF_ID_is_Branch !== 1'b0) begin failures++; $display("FAIL rst_isbr got=%b exp=0", IF_ID_is_Branch); end
      checks++; if ({IF_ID_rs1, IF_ID_rs2} !== 10'd0) begin failures++; $display("FAIL rst_rs got=%h exp=0", {IF_ID_rs1, IF_ID_rs2}); end
`ifdef IF_PERF_COUNTER_EN
      checks++; if ({perf_stall_cnt, perf_flush_cnt} !== 64'd0) begin failures++; $display("FAIL rst_perf got=%h exp=0", {perf_stall_cnt, perf_flush_cnt}); end
`endif
      rst = 1'b0;
      step();
      checks++; if (imem_bus.imem_addr !== 32'h4) begin failures++; $display("FAIL seq_addr4 got=%h exp=%h", imem_bus.imem_addr, 32'h4); end
      checks++; if (IF_ID_pc !== 32'h0 || IF_ID_valid !== 1'b1) begin failures++; $display("FAIL first_fetch pc=%h valid=%b exp pc=0 valid=1", IF_ID_pc, IF_ID_valid); end
      checks++; if (IF_ID_instr !== 32'h33) begin failures++; $display("FAIL first_instr got=%h exp=%h", IF_ID_instr, 32'h33); end
   endtask

   task automatic test_predecode();
      step();
      checks++; if (imem_bus.imem_addr !== 32'h8) begin failures++; $display("FAIL seq_addr8 got=%h exp=%h", imem_bus.imem_addr, 32'h8); end
      checks++; if (IF_ID_is_Branch !== 1'b1) begin failures++; $display("FAIL beq_isbr got=%b exp=1", IF_ID_is_Branch); end
      checks++; if (IF_ID_rs1 !== 5'd1 || IF_ID_rs2 !== 5'd2) begin failures++; $display("FAIL beq_rs rs1=%0d rs2=%0d exp 1 2", IF_ID_rs1, IF_ID_rs2); end
      checks++; if (IF_ID_pc !== 32'h4 || IF_ID_pc_plus4 !== 32'h8) begin failures++; $display("FAIL beq_pc pc=%h pc4=%h exp 4 8", IF_ID_pc, IF_ID_pc_plus4); end
   endtask

   task automatic test_stall();
`ifdef IF_PERF_COUNTER_EN
      stall_base = perf_stall_cnt;
`endif
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (imem_bus.imem_addr !== 32'h8) begin failures++; $display("FAIL stall_addr got=%h exp=%h", imem_bus.imem_addr, 32'h8); end
         checks++; if (IF_ID_pc !== 32'h4 || IF_ID_instr !== 32'h0020_8463 || IF_ID_valid !== 1'b1) begin failures++; $display("FAIL stall_hold pc=%h instr=%h valid=%b", IF_ID_pc, IF_ID_instr, IF_ID_valid); end
      end
`ifdef IF_PERF_COUNTER_EN
      checks++; if (perf_stall_cnt !== stall_base + 32'd2) begin failures++; $display("FAIL perf_stall2 got=%0d exp=%0d", perf_stall_cnt, stall_base + 32'd2); end
`endif
      stall = 1'b0;
      step();
      checks++; if (imem_bus.imem_addr !== 32'hC) begin failures++; $display("FAIL post_stall_addr got=%h exp=%h", imem_bus.imem_addr, 32'hC); end
      checks++; if (IF_ID_instr !== 32'h00C5_8533 || IF_ID_is_Branch !== 1'b0) begin failures++; $display("FAIL add_isbr instr=%h isbr=%b exp add/0", IF_ID_instr, IF_ID_is_Branch); end
   endtask

   task automatic test_redirect();
      step();
      checks++; if (imem_bus.imem_addr !== 32'h10) begin failures++; $display("FAIL pre_redir_addr got=%h exp=%h", imem_bus.imem_addr, 32'h10); end
      branch_taken = 1'b1; branch_target = 32'h100;
      step();
      branch_taken = 1'b0;
      checks++; if (imem_bus.imem_addr !== 32'h100) begin failures++; $display("FAIL redir_addr got=%h exp=%h", imem_bus.imem_addr, 32'h100); end
      checks++; if (IF_ID_valid !== 1'b0 || IF_ID_instr !== 32'h13 || IF_ID_pc !== 32'h10) begin failures++; $display("FAIL redir_flush valid=%b instr=%h pc=%h", IF_ID_valid, IF_ID_instr, IF_ID_pc); end
      checks++; if (IF_ID_rs1 !== 5'd0 || IF_ID_rs2 !== 5'd0 || IF_ID_is_Branch !== 1'b0) begin failures++; $display("FAIL bubble_decode rs1=%0d rs2=%0d isbr=%b", IF_ID_rs1, IF_ID_rs2, IF_ID_is_Branch); end
      step();
      checks++; if (IF_ID_pc !== 32'h100 || IF_ID_valid !== 1'b1 || IF_ID_instr !== 32'h0000_0033) begin failures++; $display("FAIL redir_arrive pc=%h valid=%b instr=%h", IF_ID_pc, IF_ID_valid, IF_ID_instr); end
   endtask

   task automatic test_stall_redirect();
      branch_taken = 1'b1; branch_target = 32'h1C;
      step();
      branch_taken = 1'b0;
      step();
      checks++; if (imem_bus.imem_addr !== 32'h20) begin failures++; $display("FAIL setup_addr20 got=%h exp=%h", imem_bus.imem_addr, 32'h20); end
`ifdef IF_PERF_COUNTER_EN
      stall_base = perf_stall_cnt; flush_base = perf_flush_cnt;
`endif
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
      step();
      checks++; if (imem_bus.imem_addr !== 32'h20) begin failures++; $display("FAIL sr_addr got=%h exp=%h", imem_bus.imem_addr, 32'h20); end
      checks++; if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h1C) begin failures++; $display("FAIL sr_noflush valid=%b pc=%h exp 1 1c", IF_ID_valid, IF_ID_pc); end
`ifdef IF_PERF_COUNTER_EN
      checks++; if (perf_stall_cnt !== stall_base + 32'd1 || perf_flush_cnt !== flush_base) begin failures++; $display("FAIL sr_perf stall=%0d flush=%0d exp %0d %0d", perf_stall_cnt, perf_flush_cnt, stall_base + 32'd1, flush_base); end
`endif
      stall = 1'b0; branch_taken = 1'b0;
      step();
      checks++; if (imem_bus.imem_addr !== 32'h24 || IF_ID_pc !== 32'h20) begin failures++; $display("FAIL sr_resume addr=%h pc=%h exp 24 20", imem_bus.imem_addr, IF_ID_pc); end
   endtask

   task automatic test_boundaries();
`ifdef IF_PERF_COUNTER_EN
      flush_base = perf_flush_cnt;
`endif
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
      step();
      branch_taken = 1'b0;
      checks++; if (imem_bus.imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_setup got=%h exp=fffffffc", imem_bus.imem_addr); end
`ifdef IF_PERF_COUNTER_EN
      checks++; if (perf_flush_cnt !== flush_base + 32'd1) begin failures++; $display("FAIL perf_flush1 got=%0d exp=%0d", perf_flush_cnt, flush_base + 32'd1); end
`endif
      step();
      checks++; if (imem_bus.imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", imem_bus.imem_addr); end
      checks++; if (IF_ID_pc !== 32'hFFFF_FFFC || IF_ID_pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4 pc=%h pc4=%h exp fffffffc 0", IF_ID_pc, IF_ID_pc_plus4); end
      branch_taken = 1'b1; branch_target = 32'h103;
      step();
      branch_taken = 1'b0;
      checks++; if (imem_bus.imem_addr !== 32'h100) begin failures++; $display("FAIL align_addr got=%h exp=100", imem_bus.imem_addr); end
      step();
      stall = 1'b1; rst = 1'b1;
      step();
      checks++; if (imem_bus.imem_addr !== 32'h0 || IF_ID_valid !== 1'b0 || IF_ID_instr !== 32'h13 || IF_ID_pc !== 32'h0) begin failures++; $display("FAIL rst_in_stall addr=%h valid=%b instr=%h pc=%h", imem_bus.imem_addr, IF_ID_valid, IF_ID_instr, IF_ID_pc); end
`ifdef IF_PERF_COUNTER_EN
      checks++; if ({perf_stall_cnt, perf_flush_cnt} !== 64'd0) begin failures++; $display("FAIL rst_in_stall_perf got=%h exp=0", {perf_stall_cnt, perf_flush_cnt}); end
`endif
      stall = 1'b0; rst = 1'b0;
      step();
      checks++; if (imem_bus.imem_addr !== 32'h4 || IF_ID_valid !== 1'b1) begin failures++; $display("FAIL post_rst_fetch addr=%h valid=%b", imem_bus.imem_addr, IF_ID_valid); end
   endtask

   initial begin
      test_reset();
      test_predecode();
      test_stall();
      test_redirect();
      test_stall_redirect();
      test_boundaries();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch stage plus IF/ID pipeline register for the 5-stage RISC-V core.
- Owns the PC, drives the instruction-memory address, and latches the fetched instruction.
- Pre-decodes IF_ID_rs1, IF_ID_rs2 and IF_ID_is_Branch, which feed the hazard-detect and forwarding logic directly downstream.
- Consumes the hazard unit's stall and the ID-stage branch redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on reset and flush.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  from hazard detect; freezes PC and IF/ID.
- branch_taken  input  1  ID-stage redirect (taken branch or JAL/JALR resolved in ID).
- branch_target  input  32  redirect address.
- imem_addr  output  32  current PC to instruction memory (asynchronous read).
- imem_rdata  input  32  instruction at imem_addr, valid in the same cycle.
- IF_ID_pc  output  32  PC of the latched instruction.
- IF_ID_pc_plus4  output  32  IF_ID_pc + 4, for link writes.
- IF_ID_instr  output  32  latched instruction.
- IF_ID_valid  output  1  1 = real instruction; 0 = bubble.
- IF_ID_rs1  output  5  IF_ID_instr[19:15].
- IF_ID_rs2  output  5  IF_ID_instr[24:20].
- IF_ID_is_Branch  output  1  IF_ID_valid && opcode in {7'b1100011 (B-type), 7'b1100111 (JALR)}.

Behaviour:
- Reset is synchronous and active-high; it is sampled on the clk edge and dominates all other inputs:
  - PC <= RESET_PC; IF_ID_instr <= NOP_INSTR; IF_ID_pc <= RESET_PC; IF_ID_valid <= 0.
  - Derived outputs after reset: IF_ID_rs1 = 0, IF_ID_rs2 = 0, IF_ID_is_Branch = 0, imem_addr = RESET_PC.
- imem_addr = PC, combinational from the PC register.
- Per-cycle update priority when rst = 0: stall > branch_taken > normal.
  - Stall (stall = 1): PC and every IF/ID field hold. A branch_taken asserted in the same cycle is ignored and is not remembered. The ID stage must not resolve a branch while stalled.
  - Redirect (stall = 0, branch_taken = 1):
    - PC <= {branch_target[31:2], 2'b00}; bits [1:0] are forced to zero.
    - IF/ID is flushed: IF_ID_instr <= NOP_INSTR, IF_ID_valid <= 0, IF_ID_pc <= current PC.
    - The wrong-path instruction is discarded, giving a one-bubble penalty.
  - Normal: PC <= PC + 4; IF_ID_instr <= imem_rdata; IF_ID_pc <= PC; IF_ID_valid <= 1.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. IF_ID_pc_plus4 wraps the same way.
- Latency: an instruction fetched at PC in cycle N is presented on the IF_ID_* outputs from cycle N+1, or later if stalled.
- Pre-decode is combinational from the IF/ID register outputs only. It never depends on imem_rdata, so it is stable for the whole cycle.
- Bubble encoding: rs1 = rs2 = 0, so downstream hazard and forwarding compares against rd are benign.
- Reset asserted mid-stall or mid-redirect: the reset values are applied on that edge and the pending stall or redirect is lost.

Optional Feature:
- Macro: IF_PERF_COUNTER_EN.
- When defined, two outputs are added:
  - perf_stall_cnt[31:0]: increments on every edge with rst = 0 and stall = 1.
  - perf_flush_cnt[31:0]: increments on every edge that performs a redirect. A redirect suppressed by stall is not counted.
  - Both counters saturate at 32'hFFFF_FFFF and clear to 0 on rst.
- When undefined: these ports and their registers do not exist, and the remaining behaviour is identical.

Test Plan:
1. Reset: hold rst 2 cycles, then release.
   - While in reset: imem_addr = 0x0, IF_ID_valid = 0, IF_ID_instr = 0x00000013, IF_ID_is_Branch = 0.
   - After release: imem_addr sequence 0x0, 0x4, 0x8; IF_ID_pc = 0x0 one cycle after the first fetch.
2. Pre-decode: imem_rdata = 0x00208463 (beq x1,x2) at PC 0x4.
   - Next cycle: IF_ID_is_Branch = 1, IF_ID_rs1 = 1, IF_ID_rs2 = 2, IF_ID_pc = 0x4, IF_ID_pc_plus4 = 0x8.
   - With 0x00C58533 (add): IF_ID_is_Branch = 0.
3. Stall: stall = 1 for 2 cycles with PC = 0x8.
   - imem_addr stays 0x8 and all IF_ID_* outputs are unchanged.
   - After stall drops, imem_addr = 0xC on the following cycle.
4. Redirect: branch_taken = 1, branch_target = 0x100 at PC 0x10.
   - Next cycle: imem_addr = 0x100, IF_ID_valid = 0, IF_ID_instr = 0x00000013.
   - Cycle after: IF_ID_pc = 0x100, IF_ID_valid = 1.
5. Stall + redirect in the same cycle: stall = 1, branch_taken = 1, target = 0x200 at PC 0x20.
   - PC stays 0x20 and there is no flush. When stall is released with branch_taken = 0, fetch continues at 0x24.
   - With IF_PERF_COUNTER_EN: perf_stall_cnt = +1, perf_flush_cnt = +0.
6. Boundaries:
   - PC 0xFFFFFFFC, normal step: imem_addr = 0x0.
   - Redirect target 0x103: imem_addr = 0x100.
   - rst asserted during stall: reset values are applied on that edge.
